// File: rtl/wfid_retire_arbiter.sv
// wfid_retire_arbiter: tracks live WF IDs and serialises retirements into a round-robin valid/ack done stream
module wfid_retire_arbiter #(
  parameter int NUM_WF = 40,
  parameter int ID_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_wr,
  input  logic [ID_W-1:0]   alloc_id,
  input  logic [NUM_WF-1:0] retire_pulse,
  input  logic              done_ack,
  output logic              done_valid,
  output logic [ID_W-1:0]   WF_id_done,
  output logic [NUM_WF-1:0] vacant,
  output logic [ID_W-1:0]   pending_count,
  output logic              retire_err
);
  logic [NUM_WF-1:0] active, pending, active_n, pending_n, cleared, legal, pend_left, alloc_oh;
  logic [ID_W-1:0] rr_ptr, next_ptr;
  logic [ID_W:0] win;
  logic ack;
  function automatic logic [ID_W:0] pick(input logic [NUM_WF-1:0] m, input logic [ID_W-1:0] p);
    logic [ID_W:0] r;
    int j;
    r = '0;
    for (int k = NUM_WF - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= NUM_WF) j = j - NUM_WF;
      if (m[j]) r = {1'b1, ID_W'(j)};
    end
    return r;
  endfunction
  always_comb begin
    ack       = done_valid & done_ack;
    cleared   = ack ? NUM_WF'(1) << WF_id_done : '0;
    alloc_oh  = (alloc_wr && int'(alloc_id) < NUM_WF) ? NUM_WF'(1) << alloc_id : '0;
    pend_left = pending & ~cleared;
    // the acked ID is still pending this cycle, so a retire for it is rejected here too
    legal     = retire_pulse & active & ~pending;
    pending_n = pend_left | legal;
    active_n  = (active & ~cleared) | alloc_oh;
    next_ptr  = (WF_id_done == ID_W'(NUM_WF - 1)) ? '0 : WF_id_done + ID_W'(1);
    win       = pick(done_valid ? pend_left : pending, ack ? next_ptr : rr_ptr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      active        <= '0;
      pending       <= '0;
      rr_ptr        <= '0;
      done_valid    <= 1'b0;
      WF_id_done    <= '0;
      vacant        <= '1;
      pending_count <= '0;
      retire_err    <= 1'b0;
    end else begin
      active        <= active_n;
      pending       <= pending_n;
      vacant        <= ~active_n;
      pending_count <= ID_W'($countones(pending_n));
      retire_err    <= |(retire_pulse & ~legal);
      if (ack) rr_ptr <= next_ptr;
      if (!done_valid || ack) begin
        done_valid <= win[ID_W];
        if (win[ID_W]) WF_id_done <= win[ID_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_wfid_retire_arbiter.sv
// tb_wfid_retire_arbiter: scoreboard bench comparing the arbiter against a set-based reference model
module tb_wfid_retire_arbiter;
  logic clk = 1'b0, rst = 1'b1, alloc_wr = 1'b0, done_ack = 1'b0;
  logic [5:0] alloc_id = '0;
  logic [39:0] retire_pulse = '0;
  logic done_valid, retire_err;
  logic [5:0] WF_id_done, pending_count;
  logic [39:0] vacant;
  typedef struct {
    bit v;
    int id;
    bit [39:0] vac;
    int cnt;
    bit err;
    bit chk_id;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  bit [39:0] m_act = '0, m_pend = '0;
  int m_ptr = 0, m_id = 0;
  bit m_val = 0;
  always #5 clk = ~clk;
  wfid_retire_arbiter #(.NUM_WF(40), .ID_W(6)) dut (
    .clk(clk), .rst(rst), .alloc_wr(alloc_wr), .alloc_id(alloc_id),
    .retire_pulse(retire_pulse), .done_ack(done_ack), .done_valid(done_valid),
    .WF_id_done(WF_id_done), .vacant(vacant), .pending_count(pending_count),
    .retire_err(retire_err)
  );
  function automatic bit [39:0] b(input int n);
    return 40'b1 << n;
  endfunction
  function automatic int find(input bit [39:0] m, input int p);
    for (int k = 0; k < 40; k++) if (m[(p + k) % 40]) return (p + k) % 40;
    return -1;
  endfunction
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_step(input bit r, input bit aw, input int aid, input bit [39:0] rp, input bit a);
    bit acked, err;
    bit [39:0] na, np;
    int w;
    exp_t e;
    err = 0;
    if (r) begin
      m_act = '0; m_pend = '0; m_ptr = 0; m_val = 0; m_id = 0;
    end else begin
      acked = m_val && a;
      na = m_act;
      np = m_pend;
      if (acked) begin
        na[m_id] = 0;
        np[m_id] = 0;
      end
      for (int i = 0; i < 40; i++)
        if (rp[i]) begin
          if (m_act[i] && !m_pend[i] && !(acked && i == m_id)) np[i] = 1;
          else err = 1;
        end
      if (aw && aid < 40) na[aid] = 1;
      if (!m_val) begin
        w = find(m_pend, m_ptr);
        if (w >= 0) begin
          m_val = 1;
          m_id = w;
        end
      end else if (acked) begin
        m_ptr = (m_id + 1) % 40;
        w = find(m_pend & ~b(m_id), m_ptr);
        if (w >= 0) m_id = w;
        else m_val = 0;
      end
      m_act = na;
      m_pend = np;
    end
    e.v = m_val; e.id = m_id; e.vac = ~m_act; e.cnt = $countones(m_pend);
    e.err = err; e.chk_id = m_val || r;
    q.push_back(e);
  endtask
  task automatic cyc(input bit r, input bit aw, input int aid, input bit [39:0] rp, input bit a);
    @(negedge clk);
    rst = r; alloc_wr = aw; alloc_id = 6'(aid); retire_pulse = rp; done_ack = a;
    model_step(r, aw, aid, rp, a);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("done_valid", done_valid, e.v);
        if (e.chk_id) chk("WF_id_done", WF_id_done, e.id);
        chk("vacant", vacant, e.vac);
        chk("pending_count", pending_count, e.cnt);
        chk("retire_err", retire_err, e.err);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    bit [39:0] rp;
    int i;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 3, 0, 1);
    cyc(0, 1, 7, 0, 1);
    cyc(0, 0, 0, b(3) | b(7), 1);
    repeat (4) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 2, 0, 0);
    cyc(0, 1, 9, 0, 0);
    cyc(0, 0, 0, b(2) | b(9), 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 39, 0, 1);
    cyc(0, 1, 1, 0, 1);
    cyc(0, 0, 0, b(39) | b(1), 0);
    cyc(0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 5, 0, 0);
    cyc(0, 1, 6, 0, 0);
    cyc(0, 0, 0, b(5), 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, b(6), 0);
    repeat (4) cyc(0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, b(12), 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 10, 0, 0);
    cyc(0, 1, 11, 0, 0);
    cyc(0, 1, 12, 0, 0);
    cyc(0, 0, 0, b(10) | b(11) | b(12), 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, b(0), 0);
    repeat (3) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 45, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      rp = '0;
      repeat (3) if ($urandom % 2 == 0) begin
        i = int'($urandom % 40);
        if ((m_act[i] && !m_pend[i]) || $urandom % 8 == 0) rp[i] = 1;
      end
      cyc($urandom % 200 == 0, $urandom % 2 == 0, int'($urandom % 48), rp, $urandom % 4 != 0);
    end
    cyc(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
